// File: rtl/core_input_ctrl_if.sv
// Bus bundle for core_input_ctrl: per-lane activation/weight inputs, shared
// write/read strobes, per-lane empty flags and registered skewed outputs.
interface core_input_ctrl_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 8
);
  logic [DW-1:0] ainport [N];
  logic [DW-1:0] winport [N];
  logic          write;
  logic          read;
  logic [N-1:0]  aemptys;
  logic [N-1:0]  wemptys;
  logic [DW-1:0] as [N];
  logic [DW-1:0] ws [N];

  modport master (
    output ainport, winport, write, read,
    input  aemptys, wemptys, as, ws
  );

  modport slave (
    input  ainport, winport, write, read,
    output aemptys, wemptys, as, ws
  );
endinterface

// File: rtl/core_input_ctrl.sv
// Input staging for an NxN systolic core: one FIFO per activation row and per
// weight column, written in parallel and drained with a diagonal read skew.
module core_input_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 16
) (
  input logic               clk,
  input logic               rstn,
  core_input_ctrl_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [N-2:0] rd_dly;
  logic [N-1:0] rd_en;

  // rd_en[i] is read delayed by i cycles; lane 0 takes read directly
  assign rd_en = {rd_dly, bus.read};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_dly <= '0;
    else       rd_dly <= rd_en[N-2:0];
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    // k = 0 is the activation FIFO, k = 1 the weight FIFO of this lane
    for (genvar k = 0; k < 2; k++) begin : g_fifo
      logic [DW-1:0] mem [DEPTH];
      logic [AW-1:0] wr_ptr;
      logic [AW-1:0] rd_ptr;
      logic [AW:0]   count;
      logic [DW-1:0] din;
      logic [DW-1:0] dout;
      logic          push;
      logic          pop;

      assign din  = (k == 0) ? bus.ainport[i] : bus.winport[i];
      assign push = bus.write && (count != (AW+1)'(DEPTH));
      assign pop  = rd_en[i] && (count != '0);

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
      end

      // Pop reads the pre-edge head, so a same-cycle push to an empty lane is never bypassed
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
          dout   <= '0;
        end else begin
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (pop)  rd_ptr <= rd_ptr + 1'b1;
          dout <= pop ? mem[rd_ptr] : '0;
          case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
        end
      end
    end

    assign bus.as[i]      = g_fifo[0].dout;
    assign bus.ws[i]      = g_fifo[1].dout;
    assign bus.aemptys[i] = (g_fifo[0].count == '0);
    assign bus.wemptys[i] = (g_fifo[1].count == '0);
  end
endmodule

// File: tb/tb_core_input_ctrl.sv
// Directed bench for core_input_ctrl: table of per-cycle vectors plus
// hand-written streaming, overflow and mid-stream reset sequences.
module tb_core_input_ctrl;
  localparam int unsigned DW    = 8;
  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 16;

  typedef logic [DW-1:0] lanes_t [N];

  typedef struct {
    bit           rstn;
    bit           wr;
    bit           rd;
    logic [7:0]   a;
    logic [7:0]   w;
    logic [7:0]   ea;
    logic [7:0]   ew;
    logic [N-1:0] vmask;
    logic [N-1:0] ae;
    logic [N-1:0] we;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  core_input_ctrl_if #(.DW(DW), .N(N)) bus();

  core_input_ctrl #(.DW(DW), .N(N), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Lane i always carries base + 16*i so lane mix-ups are visible
  task automatic drive(bit wr, bit rd, logic [7:0] a, logic [7:0] w);
    bus.write = wr;
    bus.read  = rd;
    for (int i = 0; i < N; i++) begin
      bus.ainport[i] = 8'(a + 16 * i);
      bus.winport[i] = 8'(w + 16 * i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string tag, int lane, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane %0d: got %0h, expected %0h", tag, lane, act, exp);
    end
  endtask

  task automatic check(string tag, lanes_t ea, lanes_t ew, logic [N-1:0] ae, logic [N-1:0] we);
    cmp({tag, " aemptys"}, -1, 32'(bus.aemptys), 32'(ae));
    cmp({tag, " wemptys"}, -1, 32'(bus.wemptys), 32'(we));
    for (int i = 0; i < N; i++) begin
      cmp({tag, " as"}, i, 32'(bus.as[i]), 32'(ea[i]));
      cmp({tag, " ws"}, i, 32'(bus.ws[i]), 32'(ew[i]));
    end
  endtask

  function automatic lanes_t mk(logic [7:0] base, logic [N-1:0] vm);
    lanes_t r;
    for (int i = 0; i < N; i++) r[i] = vm[i] ? 8'(base + 16 * i) : 8'h00;
    return r;
  endfunction

  task automatic add(bit rs, bit wr, bit rd, int a, int w, int ea, int ew, int vm, int ae, int we);
    vec_t v;
    v.rstn = rs; v.wr = wr; v.rd = rd;
    v.a = 8'(a); v.w = 8'(w); v.ea = 8'(ea); v.ew = 8'(ew);
    v.vmask = N'(vm); v.ae = N'(ae); v.we = N'(we);
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    lanes_t       ea, ew;
    logic [N-1:0] ae;
    rstn = 1'b0;
    drive(0, 0, 8'h00, 8'h00);

    // reset held, then single write and one-cycle read pulse
    add(0, 0, 0, 0, 0, 0, 0, 0, 'hFF, 'hFF);
    add(0, 0, 0, 0, 0, 0, 0, 0, 'hFF, 'hFF);
    add(1, 1, 0, 1, 1, 0, 0, 0, 'h00, 'h00);
    add(1, 0, 1, 0, 0, 1, 1, 'h01, 'h01, 'h01);
    for (int k = 1; k < N; k++) add(1, 0, 0, 0, 0, 1, 1, 1 << k, (1 << (k + 1)) - 1, (1 << (k + 1)) - 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 'hFF, 'hFF);
    // reads on empty FIFOs, then flush the skew chain
    for (int k = 0; k < 10; k++) add(1, 0, 1, 0, 0, 0, 0, 0, 'hFF, 'hFF);
    for (int k = 0; k < N; k++)  add(1, 0, 0, 0, 0, 0, 0, 0, 'hFF, 'hFF);
    // push and read together on empty lanes: lane 0 not bypassed, lanes 1.. pop later
    add(1, 1, 1, 5, 9, 0, 0, 0, 'h00, 'h00);
    for (int k = 1; k < N; k++) add(1, 0, 0, 0, 0, 5, 9, 1 << k, ((1 << (k + 1)) - 1) & ~1, ((1 << (k + 1)) - 1) & ~1);
    add(1, 0, 1, 0, 0, 5, 9, 'h01, 'hFF, 'hFF);
    for (int k = 0; k < N; k++) add(1, 0, 0, 0, 0, 0, 0, 0, 'hFF, 'hFF);

    foreach (tbl[n]) begin
      rstn = tbl[n].rstn;
      drive(tbl[n].wr, tbl[n].rd, tbl[n].a, tbl[n].w);
      tick();
      check($sformatf("vec%0d", n), mk(tbl[n].ea, tbl[n].vmask), mk(tbl[n].ew, tbl[n].vmask),
            tbl[n].ae, tbl[n].we);
    end

    // streaming: write+read 16 cycles, read-only 8, idle 8
    do_reset();
    for (int j = 0; j < 32; j++) begin
      if (j < 16)      drive(1, 1, 8'(j + 1), 8'(2 * j + 1));
      else if (j < 24) drive(0, 1, 8'h00, 8'h00);
      else             drive(0, 0, 8'h00, 8'h00);
      tick();
      for (int i = 0; i < N; i++) begin
        int f, v, pushes, pops;
        f      = (i == 0) ? 1 : i;
        pushes = (j + 1 < 16) ? j + 1 : 16;
        pops   = (j < f) ? 0 : ((j - f + 1 < 16) ? j - f + 1 : 16);
        v      = j - f + 1;
        ea[i]  = (j >= f && j <= f + 15) ? 8'(v + 16 * i) : 8'h00;
        ew[i]  = (j >= f && j <= f + 15) ? 8'(2 * v - 1 + 16 * i) : 8'h00;
        ae[i]  = (pushes == pops);
      end
      check($sformatf("stream%0d", j), ea, ew, ae, ae);
    end

    // overflow: 17 writes, 16+N reads; 17th value dropped
    do_reset();
    for (int c = 0; c < 17; c++) begin
      drive(1, 0, 8'(c + 1), 8'(2 * (c + 1)));
      tick();
      check($sformatf("ovf_wr%0d", c), mk(0, 0), mk(0, 0), '0, '0);
    end
    for (int j = 0; j < 16 + N; j++) begin
      drive(0, 1, 8'h00, 8'h00);
      tick();
      for (int i = 0; i < N; i++) begin
        int v;
        v     = j - i + 1;
        ea[i] = (j >= i && j - i < 16) ? 8'(v + 16 * i) : 8'h00;
        ew[i] = (j >= i && j - i < 16) ? 8'(2 * v + 16 * i) : 8'h00;
        ae[i] = (j >= i + 15);
      end
      check($sformatf("ovf_rd%0d", j), ea, ew, ae, ae);
    end

    // asynchronous reset mid-stream, then clean restart
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      drive(1, 0, 8'(c), 8'(c));
      tick();
    end
    drive(0, 1, 8'h00, 8'h00);
    tick();
    check("mid_pre", mk(1, 'h01), mk(1, 'h01), '0, '0);
    drive(0, 0, 8'h00, 8'h00);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_async", mk(0, 0), mk(0, 0), '1, '1);
    @(negedge clk);
    rstn = 1'b1;
    drive(1, 0, 8'h40, 8'h50);
    tick();
    check("restart_wr", mk(0, 0), mk(0, 0), '0, '0);
    drive(0, 1, 8'h00, 8'h00);
    tick();
    check("restart_l0", mk(8'h40, 'h01), mk(8'h50, 'h01), 'h01, 'h01);
    drive(0, 0, 8'h00, 8'h00);
    tick();
    check("restart_l1", mk(8'h40, 'h02), mk(8'h50, 'h02), 'h03, 'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
